cic_layer_sequencer: RTL and testbench

//  Top-level scheduler for the CONV accelerator: owns the single result-memory port (csel/crd/cwr/caddr)
//  and sequences three phases: L0 conv write-back, L1 2x2 max-pool, L2 flatten. Issues per-pixel

---
 rtl/cic_pkg.sv | 33 +++
 rtl/cic_pool_unit.sv | 88 ++++++++
 rtl/cic_layer_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_cic_layer_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared definitions for the CONV accelerator layer sequencer: memory-select codes,
// FSM state encoding and default geometry.
package cic_pkg;

  localparam int unsigned DW_DEF    = 20;
  localparam int unsigned LOG2W_DEF = 6;

  typedef enum logic [2:0] {
    NSEL = 3'b000,
    L0K0 = 3'b001,
    L0K1 = 3'b010,
    L1K0 = 3'b011,
    L1K1 = 3'b100,
    L2F  = 3'b101
  } csel_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CONV_REQ,
    S_CONV_WAIT,
    S_WR_K0,
    S_WR_K1,
    S_POOL_RD0,
    S_POOL_RD1,
    S_POOL_RD2,
    S_POOL_RD3,
    S_POOL_LAST,
    S_WR_L1,
    S_WR_L2,
    S_DONE
  } state_e;

endpackage

// File: rtl/cic_pool_unit.sv
// 2x2 max-pool index walker (pr, pc, kernel) with address generation and a running-max register.
// Address/max outputs reflect the post-update (next-cycle) indices so the caller can register them.
module cic_pool_unit
  import cic_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned LOG2W = LOG2W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear_i,
  input  logic                 adv_i,
  input  logic                 fold_i,
  input  logic                 first_i,
  input  logic [1:0]           beat_i,
  input  logic [DW-1:0]        data_i,
  output logic                 k_o,
  output logic                 k_nxt_o,
  output logic                 last_o,
  output logic [2*LOG2W-1:0]   rd_addr_o,
  output logic [2*LOG2W-1:0]   l1_addr_o,
  output logic [2*LOG2W-1:0]   l2_addr_o,
  output logic [DW-1:0]        max_nxt_o
);

  localparam int unsigned PW = LOG2W - 1;
  localparam int unsigned AW = 2 * LOG2W;

  logic [PW-1:0] pr_q, pr_d;
  logic [PW-1:0] pc_q, pc_d;
  logic          k_q, k_d;
  logic [DW-1:0] max_q, max_d;

  // Raster walk over pooled outputs; wrapping the last one moves on to kernel 1.
  always_comb begin
    pr_d = pr_q;
    pc_d = pc_q;
    k_d  = k_q;
    if (clear_i) begin
      pr_d = '0;
      pc_d = '0;
      k_d  = 1'b0;
    end else if (adv_i) begin
      if (pc_q == '1) begin
        pc_d = '0;
        if (pr_q == '1) begin
          pr_d = '0;
          k_d  = 1'b1;
        end else begin
          pr_d = pr_q + PW'(1);
        end
      end else begin
        pc_d = pc_q + PW'(1);
      end
    end
  end

  // First datum of a window loads unconditionally; later ones keep the unsigned maximum.
  always_comb begin
    max_d = max_q;
    if (fold_i && (first_i || (data_i > max_q))) begin
      max_d = data_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pr_q  <= '0;
      pc_q  <= '0;
      k_q   <= 1'b0;
      max_q <= '0;
    end else begin
      pr_q  <= pr_d;
      pc_q  <= pc_d;
      k_q   <= k_d;
      max_q <= max_d;
    end
  end

  assign k_o       = k_q;
  assign k_nxt_o   = k_d;
  assign last_o    = (pr_q == '1) && (pc_q == '1);
  assign rd_addr_o = {pr_d, beat_i[1], pc_d, beat_i[0]};
  assign l1_addr_o = AW'({pr_d, pc_d});
  assign l2_addr_o = AW'({pr_d, pc_d, k_d});
  assign max_nxt_o = max_d;

endmodule

// File: rtl/cic_layer_sequencer.sv
// Layer scheduler for the CONV accelerator: drives the conv engine per pixel, then pools and
// flattens the results, owning the single result-memory port throughout.
module cic_layer_sequencer
  import cic_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned LOG2W = LOG2W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ready,
  output logic               busy,
  output logic               conv_start,
  output logic [LOG2W-1:0]   conv_row,
  output logic [LOG2W-1:0]   conv_col,
  input  logic               conv_done,
  input  logic [DW-1:0]      conv_k0,
  input  logic [DW-1:0]      conv_k1,
  output logic               crd,
  output logic [2*LOG2W-1:0] caddr_rd,
  input  logic [DW-1:0]      cdata_rd,
  output logic               cwr,
  output logic [2*LOG2W-1:0] caddr_wr,
  output logic [DW-1:0]      cdata_wr,
  output logic [2:0]         csel
);

  localparam int unsigned AW = 2 * LOG2W;

  state_e           state_q, state_d;
  logic [LOG2W-1:0] r_q, r_d;
  logic [LOG2W-1:0] c_q, c_d;
  logic [DW-1:0]    k0_q, k0_d;
  logic [DW-1:0]    k1_q, k1_d;

  logic             busy_q, busy_d;
  logic             conv_start_q, conv_start_d;
  logic             crd_q, crd_d;
  logic             cwr_q, cwr_d;
  logic [AW-1:0]    caddr_rd_q, caddr_rd_d;
  logic [AW-1:0]    caddr_wr_q, caddr_wr_d;
  logic [DW-1:0]    cdata_wr_q, cdata_wr_d;
  csel_e            csel_q, csel_d;

  logic             pool_clear, pool_adv, pool_fold, pool_first;
  logic [1:0]       beat_c;
  logic             pool_k, pool_k_nxt, pool_last;
  logic [AW-1:0]    pool_rd_addr, pool_l1_addr, pool_l2_addr;
  logic [DW-1:0]    pool_max;

  // Next-state logic and pool-unit control.
  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    c_d        = c_q;
    k0_d       = k0_q;
    k1_d       = k1_q;
    pool_clear = 1'b0;
    pool_adv   = 1'b0;
    pool_fold  = 1'b0;
    pool_first = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ready) begin
          state_d = S_CONV_REQ;
          r_d     = '0;
          c_d     = '0;
        end
      end
      S_CONV_REQ:  state_d = S_CONV_WAIT;
      S_CONV_WAIT: begin
        if (conv_done) begin
          k0_d    = conv_k0;
          k1_d    = conv_k1;
          state_d = S_WR_K0;
        end
      end
      S_WR_K0: state_d = S_WR_K1;
      S_WR_K1: begin
        c_d = c_q + LOG2W'(1);
        if (c_q == '1) begin
          r_d = r_q + LOG2W'(1);
        end
        if ((r_q == '1) && (c_q == '1)) begin
          state_d    = S_POOL_RD0;
          pool_clear = 1'b1;
        end else begin
          state_d = S_CONV_REQ;
        end
      end
      S_POOL_RD0: state_d = S_POOL_RD1;
      // Read data lags crd by one cycle, so folding runs one state behind the reads.
      S_POOL_RD1: begin
        pool_fold  = 1'b1;
        pool_first = 1'b1;
        state_d    = S_POOL_RD2;
      end
      S_POOL_RD2: begin
        pool_fold = 1'b1;
        state_d   = S_POOL_RD3;
      end
      S_POOL_RD3: begin
        pool_fold = 1'b1;
        state_d   = S_POOL_LAST;
      end
      S_POOL_LAST: begin
        pool_fold = 1'b1;
        state_d   = S_WR_L1;
      end
      S_WR_L1: state_d = S_WR_L2;
      S_WR_L2: begin
        if (pool_last && pool_k) begin
          state_d = S_DONE;
        end else begin
          pool_adv = 1'b1;
          state_d  = S_POOL_RD0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Window beat for the read issued in the upcoming state.
  always_comb begin
    beat_c = 2'd0;
    case (state_d)
      S_POOL_RD1: beat_c = 2'd1;
      S_POOL_RD2: beat_c = 2'd2;
      S_POOL_RD3: beat_c = 2'd3;
      default:    beat_c = 2'd0;
    endcase
  end

  cic_pool_unit #(
    .DW    (DW),
    .LOG2W (LOG2W)
  ) u_pool (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (pool_clear),
    .adv_i     (pool_adv),
    .fold_i    (pool_fold),
    .first_i   (pool_first),
    .beat_i    (beat_c),
    .data_i    (cdata_rd),
    .k_o       (pool_k),
    .k_nxt_o   (pool_k_nxt),
    .last_o    (pool_last),
    .rd_addr_o (pool_rd_addr),
    .l1_addr_o (pool_l1_addr),
    .l2_addr_o (pool_l2_addr),
    .max_nxt_o (pool_max)
  );

  // Port values are decoded from the state being entered so they register alongside it.
  always_comb begin
    busy_d       = (state_d != S_IDLE);
    conv_start_d = (state_d == S_CONV_REQ);
    crd_d        = 1'b0;
    cwr_d        = 1'b0;
    csel_d       = NSEL;
    caddr_rd_d   = caddr_rd_q;
    caddr_wr_d   = caddr_wr_q;
    cdata_wr_d   = cdata_wr_q;
    case (state_d)
      S_WR_K0: begin
        cwr_d      = 1'b1;
        csel_d     = L0K0;
        caddr_wr_d = {r_q, c_q};
        cdata_wr_d = k0_d;
      end
      S_WR_K1: begin
        cwr_d      = 1'b1;
        csel_d     = L0K1;
        caddr_wr_d = {r_q, c_q};
        cdata_wr_d = k1_q;
      end
      S_POOL_RD0, S_POOL_RD1, S_POOL_RD2, S_POOL_RD3: begin
        crd_d      = 1'b1;
        csel_d     = pool_k_nxt ? L0K1 : L0K0;
        caddr_rd_d = pool_rd_addr;
      end
      S_WR_L1: begin
        cwr_d      = 1'b1;
        csel_d     = pool_k_nxt ? L1K1 : L1K0;
        caddr_wr_d = pool_l1_addr;
        cdata_wr_d = pool_max;
      end
      S_WR_L2: begin
        cwr_d      = 1'b1;
        csel_d     = L2F;
        caddr_wr_d = pool_l2_addr;
        cdata_wr_d = pool_max;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      r_q          <= '0;
      c_q          <= '0;
      k0_q         <= '0;
      k1_q         <= '0;
      busy_q       <= 1'b0;
      conv_start_q <= 1'b0;
      crd_q        <= 1'b0;
      cwr_q        <= 1'b0;
      caddr_rd_q   <= '0;
      caddr_wr_q   <= '0;
      cdata_wr_q   <= '0;
      csel_q       <= NSEL;
    end else begin
      state_q      <= state_d;
      r_q          <= r_d;
      c_q          <= c_d;
      k0_q         <= k0_d;
      k1_q         <= k1_d;
      busy_q       <= busy_d;
      conv_start_q <= conv_start_d;
      crd_q        <= crd_d;
      cwr_q        <= cwr_d;
      caddr_rd_q   <= caddr_rd_d;
      caddr_wr_q   <= caddr_wr_d;
      cdata_wr_q   <= cdata_wr_d;
      csel_q       <= csel_d;
    end
  end

  assign busy       = busy_q;
  assign conv_start = conv_start_q;
  assign conv_row   = r_q;
  assign conv_col   = c_q;
  assign crd        = crd_q;
  assign caddr_rd   = caddr_rd_q;
  assign cwr        = cwr_q;
  assign caddr_wr   = caddr_wr_q;
  assign cdata_wr   = cdata_wr_q;
  assign csel       = csel_q;

endmodule

// File: tb/tb_cic_layer_sequencer.sv
// Scoreboard bench: the conv responder pushes expected memory traffic, a negedge monitor
// pops and compares every read/write the sequencer issues.
`timescale 1ns/1ps
module tb_cic_layer_sequencer;
  import cic_pkg::*;

  localparam int unsigned DW    = 20;
  localparam int unsigned LOG2W = 6;
  localparam int unsigned AW    = 12;

  typedef struct packed {
    logic [2:0]    sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } acc_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             ready;
  logic             busy;
  logic             conv_start;
  logic [LOG2W-1:0] conv_row;
  logic [LOG2W-1:0] conv_col;
  logic             conv_done;
  logic [DW-1:0]    conv_k0;
  logic [DW-1:0]    conv_k1;
  logic             crd;
  logic [AW-1:0]    caddr_rd;
  logic [DW-1:0]    cdata_rd = '0;
  logic             cwr;
  logic [AW-1:0]    caddr_wr;
  logic [DW-1:0]    cdata_wr;
  logic [2:0]       csel;

  int   nvec  = 0;
  int   nfail = 0;
  acc_t exp_wr[$];
  acc_t exp_rd[$];
  logic [DW-1:0] mem [0:7][0:4095];

  cic_layer_sequencer #(.DW(DW), .LOG2W(LOG2W)) dut (
    .clk        (clk),
    .reset      (reset),
    .ready      (ready),
    .busy       (busy),
    .conv_start (conv_start),
    .conv_row   (conv_row),
    .conv_col   (conv_col),
    .conv_done  (conv_done),
    .conv_k0    (conv_k0),
    .conv_k1    (conv_k1),
    .crd        (crd),
    .caddr_rd   (caddr_rd),
    .cdata_rd   (cdata_rd),
    .cwr        (cwr),
    .caddr_wr   (caddr_wr),
    .cdata_wr   (cdata_wr),
    .csel       (csel)
  );

  always #5 clk = ~clk;

  // Result memory: one write and one registered read per cycle.
  always @(posedge clk) begin
    if (cwr) mem[csel][caddr_wr] <= cdata_wr;
    if (crd) cdata_rd <= mem[csel][caddr_rd];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    nvec++;
    if (act !== expv) begin
      nfail++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  endtask

  // Conv results: directed corner values plus a hash elsewhere.
  function automatic logic [DW-1:0] kval(input int k, input int r, input int c);
    logic [31:0] h;
    if (r == 0 && c == 5) return (k == 0) ? 20'h00123 : 20'h00456;
    if (k == 0 && r == 0 && c == 0) return 20'h00010;
    if (k == 0 && r == 0 && c == 1) return 20'hFFFFF;
    if (k == 0 && r == 1 && c == 0) return 20'h00003;
    if (k == 0 && r == 1 && c == 1) return 20'h00007;
    if (r >= 60 && c >= 60) return 20'h00000;
    if (r >= 40 && r < 42 && c >= 10 && c < 12) return 20'h00055;
    h = 32'(r) * 32'd1103 + 32'(c) * 32'd577 + 32'(k) * 32'd7919 + 32'd17;
    h = h * 32'd2654435761;
    return h[31:12];
  endfunction

  task automatic push_pool();
    logic [DW-1:0] m, v;
    int rr, cc, idx;
    for (int k = 0; k < 2; k++) begin
      for (int pr = 0; pr < 32; pr++) begin
        for (int pc = 0; pc < 32; pc++) begin
          m = '0;
          for (int b = 0; b < 4; b++) begin
            rr = 2 * pr + b / 2;
            cc = 2 * pc + b % 2;
            v  = kval(k, rr, cc);
            exp_rd.push_back('{(k == 0) ? L0K0 : L0K1, AW'(rr * 64 + cc), '0});
            if (v > m) m = v;
          end
          idx = pr * 32 + pc;
          exp_wr.push_back('{(k == 0) ? L1K0 : L1K1, AW'(idx), m});
          exp_wr.push_back('{L2F, AW'(2 * idx + k), m});
        end
      end
    end
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (conv_start) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({busy, conv_start, conv_row, conv_col, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel});
  endfunction

  task automatic run_job(input int lat, input bit abort);
    bit ok;
    int rdcnt;
    @(posedge clk); #1 ready = 1'b1;
    @(posedge clk); #1 ready = 1'b0;
    @(negedge clk);
    check("busy_after_ready", 64'(busy), 64'(1));
    for (int r = 0; r < 64; r++) begin
      for (int c = 0; c < 64; c++) begin
        wait_start(ok);
        if (!ok) begin
          nvec++;
          nfail++;
          $display("FAIL conv_start_timeout: got none want pixel (%0d,%0d)", r, c);
          finish_run();
        end
        check("conv_rowcol", 64'({conv_row, conv_col}), 64'({6'(r), 6'(c)}));
        exp_wr.push_back('{L0K0, AW'(r * 64 + c), kval(0, r, c)});
        exp_wr.push_back('{L0K1, AW'(r * 64 + c), kval(1, r, c)});
        if (r == 63 && c == 63) push_pool();
        repeat (lat) @(posedge clk);
        #1 conv_done = 1'b1;
        conv_k0 = kval(0, r, c);
        conv_k1 = kval(1, r, c);
        @(posedge clk); #1 conv_done = 1'b0;
        @(negedge clk);
      end
    end
    if (abort) begin
      rdcnt = 0;
      for (int i = 0; i < 100 && rdcnt < 3; i++) begin
        @(negedge clk);
        if (crd) rdcnt++;
      end
      check("reach_pool_rd2", 64'(rdcnt), 64'(3));
      #1 reset = 1'b1;
      #1 check("reset_midjob_outputs", all_outs(), 64'(0));
      exp_wr.delete();
      exp_rd.delete();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
    end else begin
      rdcnt = 0;
      for (int i = 0; i < 2000 && rdcnt < 50; i++) begin
        @(negedge clk);
        if (crd) rdcnt++;
      end
      #1 conv_done = 1'b1;
      conv_k0 = '1;
      conv_k1 = '1;
      @(posedge clk); #1 conv_done = 1'b0;
      ready = 1'b1;
      @(posedge clk); #1 ready = 1'b0;
      for (int i = 0; i < 20000 && exp_wr.size() != 0; i++) @(negedge clk);
      check("all_writes_seen", 64'(exp_wr.size()), 64'(0));
      for (int i = 0; i < 4 && busy; i++) @(negedge clk);
      check("busy_low_after_job", 64'(busy), 64'(0));
      repeat (10) @(negedge clk);
      check("stays_idle", 64'(busy), 64'(0));
      check("no_pending_reads", 64'(exp_rd.size()), 64'(0));
    end
  endtask

  // Monitor: every memory access must match the head of its expectation queue.
  always @(negedge clk) begin : mon
    acc_t e;
    if (!reset) begin
      if (cwr) begin
        if (exp_wr.size() == 0) begin
          nvec++;
          nfail++;
          $display("FAIL unexpected_write: got sel %0d addr 0x%0h data 0x%0h want no write",
                   csel, caddr_wr, cdata_wr);
        end else begin
          e = exp_wr.pop_front();
          check("mem_write", 64'({csel, caddr_wr, cdata_wr}), 64'(e));
        end
      end
      if (crd) begin
        if (exp_rd.size() == 0) begin
          nvec++;
          nfail++;
          $display("FAIL unexpected_read: got sel %0d addr 0x%0h want no read", csel, caddr_rd);
        end else begin
          e = exp_rd.pop_front();
          check("mem_read", 64'({csel, caddr_rd}), 64'({e.sel, e.addr}));
        end
      end
      if (!crd && !cwr) check("csel_idle", 64'(csel), 64'(NSEL));
    end
  end

  initial begin : watchdog
    #2000000;
    nvec++;
    nfail++;
    $display("FAIL watchdog: got timeout want job completion");
    finish_run();
  end

  initial begin
    reset     = 1'b1;
    ready     = 1'b0;
    conv_done = 1'b0;
    conv_k0   = '0;
    conv_k1   = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", all_outs(), 64'(0));
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("idle_after_reset", 64'({busy, conv_start}), 64'(0));
    run_job(3, 1'b1);
    @(negedge clk);
    check("idle_after_abort", 64'({busy, cwr, crd}), 64'(0));
    run_job(3, 1'b0);
    finish_run();
  end

endmodule
